// File: rtl/cla_pipe_adder.sv
// Fully pipelined carry-lookahead adder/subtractor: an operand entry register followed by one
// GROUP-bit lookahead group per stage. Define CLA_PIPE_SAT_EN to clamp overflowing results.
module cla_pipe_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned GROUP = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  input  logic             sub_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_out,
  output logic             c_out,
  output logic             ovf_out
);
  localparam int unsigned NGROUPS = WIDTH / GROUP;

  // Carries c[0..GROUP] of one group; each c[i+1] is a flat OR of generate/propagate products.
  function automatic logic [GROUP:0] group_carries(input logic [GROUP-1:0] g,
                                                   input logic [GROUP-1:0] p,
                                                   input logic             cin);
    logic [GROUP:0] c;
    logic           term;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < int'(GROUP); i++) begin
      term = cin;
      for (int j = 0; j <= i; j++) term = term & p[j];
      c[i+1] = term;
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int m = j + 1; m <= i; m++) term = term & p[m];
        c[i+1] = c[i+1] | term;
      end
    end
    return c;
  endfunction

  logic             en;
  logic             out_valid_q;
  logic [WIDTH-1:0] sum_out_q;
  logic             c_out_q;
  logic             ovf_out_q;

  // Whole pipeline advances in lockstep whenever the output slot is free or being drained.
  assign en        = !out_valid_q || out_ready;
  assign in_ready  = en;
  assign out_valid = out_valid_q;
  assign sum_out   = sum_out_q;
  assign c_out     = c_out_q;
  assign ovf_out   = ovf_out_q;

  // Entry register holds the conditioned operands: B' and the initial carry.
  logic             v0_q;
  logic [WIDTH-1:0] a0_q;
  logic [WIDTH-1:0] b0_q;
  logic             c0_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v0_q <= 1'b0;
      a0_q <= '0;
      b0_q <= '0;
      c0_q <= 1'b0;
    end else if (en) begin
      v0_q <= in_valid;
      a0_q <= a_in;
      b0_q <= sub_in ? ~b_in : b_in;
      c0_q <= sub_in | c_in;
    end
  end

  // Intermediate stages: stage g resolves group g; operand skew shrinks and sum grows per stage.
  for (genvar g = 0; g < NGROUPS - 1; g++) begin : g_rank
    localparam int unsigned REM = WIDTH - GROUP * g;
    localparam int unsigned LOW = GROUP * (g + 1);

    logic [REM-1:0]       a_w;
    logic [REM-1:0]       b_w;
    logic                 c_w;
    logic                 v_w;
    logic [GROUP-1:0]     gg;
    logic [GROUP-1:0]     pp;
    logic [GROUP:0]       cc;
    logic [GROUP-1:0]     gsum;
    logic [LOW-1:0]       s_d;
    logic                 v_q;
    logic                 c_q;
    logic [REM-GROUP-1:0] a_q;
    logic [REM-GROUP-1:0] b_q;
    logic [LOW-1:0]       s_q;

    if (g == 0) begin : g_src
      assign a_w = a0_q;
      assign b_w = b0_q;
      assign c_w = c0_q;
      assign v_w = v0_q;
      assign s_d = gsum;
    end else begin : g_src
      assign a_w = g_rank[g-1].a_q;
      assign b_w = g_rank[g-1].b_q;
      assign c_w = g_rank[g-1].c_q;
      assign v_w = g_rank[g-1].v_q;
      assign s_d = {gsum, g_rank[g-1].s_q};
    end

    assign gg   = a_w[GROUP-1:0] & b_w[GROUP-1:0];
    assign pp   = a_w[GROUP-1:0] ^ b_w[GROUP-1:0];
    assign cc   = group_carries(gg, pp, c_w);
    assign gsum = pp ^ cc[GROUP-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        a_q <= '0;
        b_q <= '0;
        s_q <= '0;
      end else if (en) begin
        v_q <= v_w;
        c_q <= cc[GROUP];
        a_q <= a_w[REM-1:GROUP];
        b_q <= b_w[REM-1:GROUP];
        s_q <= s_d;
      end
    end
  end

  // Final stage: top group, carry-out, overflow and the output registers.
  logic [GROUP-1:0] fa_w;
  logic [GROUP-1:0] fb_w;
  logic             fc_w;
  logic             fv_w;
  logic [GROUP-1:0] fg;
  logic [GROUP-1:0] fp;
  logic [GROUP:0]   fcc;
  logic [GROUP-1:0] fsum;
  logic [WIDTH-1:0] wrap_d;
  logic [WIDTH-1:0] sum_d;
  logic             ovf_d;

  if (NGROUPS > 1) begin : g_final_src
    assign fa_w   = g_rank[NGROUPS-2].a_q;
    assign fb_w   = g_rank[NGROUPS-2].b_q;
    assign fc_w   = g_rank[NGROUPS-2].c_q;
    assign fv_w   = g_rank[NGROUPS-2].v_q;
    assign wrap_d = {fsum, g_rank[NGROUPS-2].s_q};
  end else begin : g_final_src
    assign fa_w   = a0_q;
    assign fb_w   = b0_q;
    assign fc_w   = c0_q;
    assign fv_w   = v0_q;
    assign wrap_d = fsum;
  end

  assign fg    = fa_w & fb_w;
  assign fp    = fa_w ^ fb_w;
  assign fcc   = group_carries(fg, fp, fc_w);
  assign fsum  = fp ^ fcc[GROUP-1:0];
  // Overflow: carry into the MSB differs from carry out of it.
  assign ovf_d = fcc[GROUP] ^ fcc[GROUP-1];

`ifdef CLA_PIPE_SAT_EN
  // Wrapped MSB set means the true result overflowed positive, clear means negative.
  always_comb begin
    sum_d = wrap_d;
    if (ovf_d) begin
      sum_d = wrap_d[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
    end
  end
`else
  assign sum_d = wrap_d;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      sum_out_q   <= '0;
      c_out_q     <= 1'b0;
      ovf_out_q   <= 1'b0;
    end else if (en) begin
      out_valid_q <= fv_w;
      sum_out_q   <= sum_d;
      c_out_q     <= fcc[GROUP];
      ovf_out_q   <= ovf_d;
    end
  end

endmodule

// File: doc/cla_pipe_adder.md
Name: cla_pipe_adder

Overview:
- Parametrised, fully pipelined carry-lookahead adder/subtractor; successor to the 4-bit registered CLA.
- Operands are split into GROUP-bit lookahead groups. Each pipeline stage resolves one group; the group carry is registered between stages, and upper operand bits are carried in skew registers.
- Valid/ready handshake on both sides with full backpressure. Signed overflow flag. Used as the datapath adder for timing/slack experiments at arbitrary width.

Parameters:
- WIDTH, 16, operand/sum width in bits; must be a multiple of GROUP.
- GROUP, 4, bits per lookahead group (one group per pipeline stage).
- NGROUPS, WIDTH/GROUP, derived local parameter; number of group stages and the pipeline latency.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand set present
- in_ready  out  1  block can accept this cycle
- a_in  in  WIDTH  operand A
- b_in  in  WIDTH  operand B
- c_in  in  1  carry in (ignored when sub_in=1)
- sub_in  in  1  1 = A - B, 0 = A + B + c_in
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts result
- sum_out  out  WIDTH  result
- c_out  out  1  carry out of MSB; for subtract, 1 = no borrow
- ovf_out  out  1  signed two's-complement overflow

Behaviour:
- Reset (reset_n low, asynchronous): all stage valid bits, operand/skew/sum/carry registers, sum_out, c_out and ovf_out clear to 0. Effective immediately; no output hold. Release is synchronous to the next clk edge.
- Global advance enable: en = !out_valid || out_ready. in_ready = en (combinational). Accept = in_valid && in_ready.
- All stages shift together when en=1 and hold when en=0. Bubbles (valid=0) travel through the pipeline and are not compacted.
- Operand conditioning at entry:
  - B' = sub_in ? ~b_in : b_in
  - C0 = sub_in ? 1 : c_in
- Stage k (1..NGROUPS):
  - Computes group k-1 from its skewed A/B' slice and the registered incoming carry.
  - G = a&b, P = a^b.
  - Group carries are fully unrolled lookahead inside the group, with no internal ripple.
  - Group sum = P ^ carries.
  - Registers the group sum bits, the group carry-out, and the remaining upper operand slices.
  - Already-resolved lower sum bits pass forward unchanged.
- Latency: a set accepted at edge T is on the outputs after edge T+NGROUPS (4 cycles at defaults), with no stalls. Each stall cycle adds one.
- Throughput: one result per cycle when out_ready=1 continuously.
- c_out = carry out of group NGROUPS-1.
- ovf_out = carry into MSB XOR carry out of MSB. The carry into the MSB is registered alongside the final stage.
- Output stability: sum_out, c_out, ovf_out and out_valid hold while out_valid && !out_ready.
- Handshake boundaries:
  - in_valid is sampled only when in_ready=1.
  - Simultaneous output pop and input accept in the same cycle is lossless.
  - Transaction order is preserved.
- Values present while out_valid=0 are don't-care after reset. Verification checks only on out_valid.
- Width rules: the full WIDTH-bit sum is produced and wraps modulo 2^WIDTH. No sign extension.
- Reset mid-stream: all in-flight transactions are discarded; none are produced after release.

Optional Feature:
- Macro: CLA_PIPE_SAT_EN.
- Defined: on ovf_out=1, sum_out is clamped to the signed limit.
  - Result MSB=1 (positive overflow): clamp to 0 followed by WIDTH-1 ones.
  - Result MSB=0 (negative overflow): clamp to 1 followed by WIDTH-1 zeros.
  - ovf_out and c_out are still reported unmodified.
  - The clamp is applied in the final stage and adds no latency.
- Undefined: wrap-around result only; no clamp logic is generated.

Test Plan:
- Defaults, out_ready=1. Accept a=0x1234, b=0x4321, c_in=0, sub=0 -> after 4 cycles out_valid=1, sum=0x5555, c_out=0, ovf=0.
- Full carry chain: a=0xFFFF, b=0x0001 -> sum=0x0000, c_out=1, ovf=0. Also a=0xFFFF, b=0x0000, c_in=1 -> same response.
- Signed overflow: a=0x7FFF, b=0x0001 -> sum=0x8000, ovf=1 (0x7FFF with CLA_PIPE_SAT_EN). Also a=0x8000, b=0xFFFF -> sum=0x7FFF, ovf=1, c_out=1 (0x8000 with CLA_PIPE_SAT_EN).
- Subtract: a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, c_out=0. Also a=0x0007, b=0x0005, sub=1, c_in=0 -> sum=0x0002, c_out=1 (c_in ignored).
- Backpressure: 8 back-to-back random sets, out_ready low for 3 cycles mid-stream -> in_ready low in exactly those cycles, outputs stable, all 8 results correct and in order, no duplicates.
- Reset mid-stream: reset_n low while 3 sets are in flight -> out_valid=0 and sum_out=0 in the same cycle. No stale results appear after release; the first new set appears 4 cycles after its accept.
